// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// fetch_unit_pkg : shared state encoding for the instruction-fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  localparam int CS_W = 2;

  typedef enum logic [CS_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_ctl.sv
// ============================================================================
// fetch_unit_ctl : fetch sequencer (state, halt/redirect pending, PC/IR enables)
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit_ctl
  import fetch_unit_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            halt,
  input  logic            pc_load,
  input  logic [AW-1:0]   pc_d,
  input  logic            mem_ack,
  input  logic            ir_ready,
  output logic [CS_W-1:0] cs,
  output logic            pc_ld,
  output logic [AW-1:0]   pc_ld_val,
  output logic            pc_inc,
  output logic            ir_ld
);

  state_t        state, state_nx;
  logic          halt_pend, halt_pend_nx;
  logic          redir_pend, redir_pend_nx;
  logic [AW-1:0] redir_pc, redir_pc_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      halt_pend  <= 1'b0;
      redir_pend <= 1'b0;
      redir_pc   <= '0;
    end else begin
      state      <= state_nx;
      halt_pend  <= halt_pend_nx;
      redir_pend <= redir_pend_nx;
      redir_pc   <= redir_pc_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    halt_pend_nx  = halt_pend;
    redir_pend_nx = redir_pend;
    redir_pc_nx   = redir_pc;
    pc_ld         = 1'b0;
    pc_ld_val     = pc_d;
    pc_inc        = 1'b0;
    ir_ld         = 1'b0;

    case (state)
      ST_IDLE: begin
        pc_ld = pc_load;
        if (run && !halt) state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        if (halt) halt_pend_nx = 1'b1;
        if (mem_ack) begin
          if (pc_load || redir_pend) begin
            // Returned word belongs to the old path: drop it and re-request
            pc_ld         = 1'b1;
            pc_ld_val     = pc_load ? pc_d : redir_pc;
            redir_pend_nx = 1'b0;
          end else begin
            ir_ld    = 1'b1;
            pc_inc   = 1'b1;
            state_nx = ST_HOLD;
          end
        end else if (pc_load) begin
          // Address must stay stable until ack, so park the target
          redir_pend_nx = 1'b1;
          redir_pc_nx   = pc_d;
        end
      end
      ST_HOLD: begin
        if (halt) halt_pend_nx = 1'b1;
        if (pc_load) begin
          pc_ld    = 1'b1;
          state_nx = ST_FETCH;
        end else if (ir_ready) begin
          state_nx = (halt_pend || halt) ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        pc_ld = pc_load;
        if (run && !halt) begin
          state_nx     = ST_FETCH;
          halt_pend_nx = 1'b0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign cs = state;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : instruction-fetch stage with req/ack memory port and IR handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          AW       = 12,
  parameter int          DW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            halt,
  input  logic            pc_load,
  input  logic [AW-1:0]   pc_d,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic [DW-1:0]   ir,
  output logic [AW-1:0]   ir_pc,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic [AW-1:0]   pc,
  output logic [CS_W-1:0] cs
);

  logic          pc_ld;
  logic [AW-1:0] pc_ld_val;
  logic          pc_inc;
  logic          ir_ld;

  fetch_unit_ctl #(.AW(AW)) u_ctl (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .halt      (halt),
    .pc_load   (pc_load),
    .pc_d      (pc_d),
    .mem_ack   (mem_ack),
    .ir_ready  (ir_ready),
    .cs        (cs),
    .pc_ld     (pc_ld),
    .pc_ld_val (pc_ld_val),
    .pc_inc    (pc_inc),
    .ir_ld     (ir_ld)
  );

  // Load beats increment; increment wraps naturally at 2^AW
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (pc_ld) begin
      pc <= pc_ld_val;
    end else if (pc_inc) begin
      pc <= pc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir    <= '0;
      ir_pc <= '0;
    end else if (ir_ld) begin
      ir    <= mem_rdata;
      ir_pc <= pc;
    end
  end

  assign mem_req  = (cs == ST_FETCH);
  assign mem_addr = pc;
  assign ir_valid = (cs == ST_HOLD);

endmodule

`default_nettype wire
